// File: rtl/aes_uart_pkg.sv
// Shared definitions for the UART-to-AES command frame receiver.
package aes_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KEY   = 3'd1,
    ST_TEXT  = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4
  } rx_state_e;

  localparam logic [7:0] CMD_ENC_DEF = 8'h45;
  localparam logic [7:0] CMD_DEC_DEF = 8'h44;
  localparam int         FRAME_BYTES = 16;

  // New bytes enter at the bottom, so the first byte of a field ends up in [127:120].
  function automatic logic [127:0] shift_in(input logic [127:0] r, input logic [7:0] b);
    return {r[119:0], b};
  endfunction

endpackage

// File: rtl/rx_timeout_timer.sv
// Inter-byte timeout: counts down the idle cycles still allowed while enabled and
// pulses expire on the cycle the allowance runs out with no byte restarting it.
module rx_timeout_timer #(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic restart,
  output logic expire
);

  localparam int              TW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]   LOAD = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    expire = 1'b0;
    if (!enable || restart) begin
      cnt_d = LOAD;
    end else if (cnt_q == '0) begin
      expire = 1'b1;
      cnt_d  = LOAD;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= LOAD;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/aes_frame_rx.sv
// Parses header + 16 key bytes + 16 text bytes from the UART byte stream and
// hands the assembled block to the AES core, holding it until the core is done.
module aes_frame_rx
  import aes_uart_pkg::*;
#(
  parameter int         TIMEOUT_CYC = 1000000,
  parameter logic [7:0] CMD_ENC     = CMD_ENC_DEF,
  parameter logic [7:0] CMD_DEC     = CMD_DEC_DEF
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic [7:0]   i_RxData,
  input  logic         i_RxValid,
  input  logic         i_Done,
  output logic         o_Start,
  output logic         o_fDec,
  output logic [127:0] o_Key,
  output logic [127:0] o_Text,
  output logic         o_Busy,
  output logic         o_Err
);

  localparam logic [3:0] LAST_IDX = 4'(FRAME_BYTES - 1);

  rx_state_e    state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] key_q, key_d, text_q, text_d;
  logic         fdec_q, fdec_d;
  logic         start_q, start_d;
  logic         busy_q, busy_d;
  logic         err_q, err_d;

  logic         frame_phase;
  logic         hdr_hit;
  logic         byte_accept;
  logic         tmo_expire;

  assign frame_phase = (state_q == ST_KEY) || (state_q == ST_TEXT);
  assign hdr_hit     = (i_RxData == CMD_ENC) || (i_RxData == CMD_DEC);
  assign byte_accept = i_RxValid && (frame_phase || ((state_q == ST_IDLE) && hdr_hit));

  rx_timeout_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk     (i_Clk),
    .rst     (i_Rst),
    .enable  (frame_phase),
    .restart (byte_accept),
    .expire  (tmo_expire)
  );

  // States:
  //   ST_IDLE  | waiting for a CMD_ENC / CMD_DEC header byte
  //   ST_KEY   | shifting in the 16 key bytes
  //   ST_TEXT  | shifting in the 16 text bytes
  //   ST_START | one-cycle start pulse to the core
  //   ST_WAIT  | block held stable until the core reports done
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    text_d  = text_q;
    fdec_d  = fdec_q;
    start_d = 1'b0;
    busy_d  = busy_q;
    err_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_RxValid && hdr_hit) begin
          fdec_d  = (i_RxData == CMD_DEC);
          cnt_d   = '0;
          state_d = ST_KEY;
        end
      end

      ST_KEY: begin
        if (i_RxValid) begin
          key_d = shift_in(key_q, i_RxData);
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == LAST_IDX) state_d = ST_TEXT;
        end else if (tmo_expire) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_TEXT: begin
        if (i_RxValid) begin
          text_d = shift_in(text_q, i_RxData);
          cnt_d  = cnt_q + 4'd1;
          if (cnt_q == LAST_IDX) begin
            start_d = 1'b1;
            busy_d  = 1'b1;
            state_d = ST_START;
          end
        end else if (tmo_expire) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_START: begin
        err_d   = i_RxValid;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        err_d = i_RxValid;
        if (i_Done) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      key_q   <= '0;
      text_q  <= '0;
      fdec_q  <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      text_q  <= text_d;
      fdec_q  <= fdec_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign o_Start = start_q;
  assign o_fDec  = fdec_q;
  assign o_Key   = key_q;
  assign o_Text  = text_q;
  assign o_Busy  = busy_q;
  assign o_Err   = err_q;

endmodule

// File: tb/tb_aes_frame_rx.sv
// Scoreboard bench for aes_frame_rx: the driver pushes expected start/error events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_aes_frame_rx;

  localparam int T = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         done;
  logic         o_start, o_fdec, o_busy, o_err;
  logic [127:0] o_key, o_text;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_cyc;

  typedef struct {
    logic [127:0] key;
    logic [127:0] text;
    logic         fdec;
    int           at;
  } exp_t;

  exp_t exp_q[$];
  int   err_q[$];
  exp_t mon_e;
  int   mon_c;

  aes_frame_rx #(
    .TIMEOUT_CYC (T)
  ) dut (
    .i_Clk     (clk),
    .i_Rst     (rst),
    .i_RxData  (rx_data),
    .i_RxValid (rx_valid),
    .i_Done    (done),
    .o_Start   (o_start),
    .o_fDec    (o_fdec),
    .o_Key     (o_key),
    .o_Text    (o_text),
    .o_Busy    (o_busy),
    .o_Err     (o_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every start pulse or error pulse must match the next expected event.
  always @(negedge clk) begin
    if (o_start) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_start", 1'b1, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("start_cycle", 128'(cyc), 128'(mon_e.at));
        chk("key", o_key, mon_e.key);
        chk("text", o_text, mon_e.text);
        chk("fdec", 128'(o_fdec), 128'(mon_e.fdec));
        chk("busy_at_start", 128'(o_busy), 128'd1);
      end
    end
    if (o_err) begin
      if (err_q.size() == 0) begin
        chk("unexpected_err", 1'b1, 1'b0);
      end else begin
        mon_c = err_q.pop_front();
        chk("err_cycle", 128'(cyc), 128'(mon_c));
      end
    end
  end

  // Called 1 time unit after a rising edge; the byte is present for exactly one cycle.
  task automatic drive_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    last_cyc = cyc;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Byte i of a 16-byte field sits at bits [127-8i -: 8].
  function automatic logic [7:0] field_byte(input logic [127:0] f, input int i);
    return f[127 - 8*i -: 8];
  endfunction

  // gap < 0 picks a random 0..3 idle gap per byte; after byte bnd the gap is T-1,
  // which places the next byte exactly in the timeout-expiry cycle.
  task automatic send_frame(input logic [7:0] hdr, input logic [127:0] key,
                            input logic [127:0] text, input int gap, input int bnd);
    exp_t e;
    logic [7:0] b;
    for (int i = 0; i < 33; i++) begin
      if (i == 0)       b = hdr;
      else if (i <= 16) b = field_byte(key, i - 1);
      else              b = field_byte(text, i - 17);
      drive_byte(b);
      if (i < 32) begin
        if (i == bnd)     idle(T - 1);
        else if (gap < 0) idle(int'($urandom_range(3, 0)));
        else              idle(gap);
      end
    end
    e.key  = key;
    e.text = text;
    e.fdec = (hdr == 8'h44);
    e.at   = last_cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic finish_frame();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("busy_in_wait", 128'(o_busy), 128'd1);
    end
    @(posedge clk); #1;
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    @(negedge clk);
    chk("busy_after_done", 128'(o_busy), 128'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_start"}, 128'(o_start), 128'd0);
    chk({tag, "_fdec"},  128'(o_fdec),  128'd0);
    chk({tag, "_key"},   o_key,         128'd0);
    chk({tag, "_text"},  o_text,        128'd0);
    chk({tag, "_busy"},  128'(o_busy),  128'd0);
    chk({tag, "_err"},   128'(o_err),   128'd0);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [7:0] rand_hdr();
    return ($urandom_range(1, 0) == 0) ? 8'h45 : 8'h44;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] k1, t1, t2, kr, tr;
    k1 = 128'h000102030405060708090a0b0c0d0e0f;
    t1 = 128'h00112233445566778899aabbccddeeff;
    t2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Garbage in IDLE; a stray done outside WAIT is also ignored.
    drive_byte(8'h00);
    idle(1);
    drive_byte(8'h41);
    done = 1'b1;
    idle(1);
    done = 1'b0;
    idle(4);
    @(negedge clk);
    chk("garbage_busy", 128'(o_busy), 128'd0);
    @(posedge clk); #1;

    send_frame(8'h45, k1, t1, 3, -1);
    finish_frame();
    send_frame(8'h44, k1, t2, 3, -1);
    finish_frame();

    // Random frames, each with one byte landing exactly on the expiry cycle.
    for (int n = 0; n < 4; n++) begin
      kr = rand128();
      tr = rand128();
      send_frame(rand_hdr(), kr, tr, -1, int'($urandom_range(31, 0)));
      finish_frame();
    end

    // Timeout during KEY, then a clean frame.
    drive_byte(8'h45);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      drive_byte(8'($urandom));
    end
    err_q.push_back(last_cyc + T + 1);
    idle(T + 4);
    kr = rand128(); tr = rand128();
    send_frame(8'h45, kr, tr, 1, -1);
    finish_frame();

    // Timeout during TEXT, then a clean frame.
    drive_byte(8'h44);
    for (int i = 0; i < 19; i++) drive_byte(8'($urandom));
    err_q.push_back(last_cyc + T + 1);
    idle(T + 4);
    kr = rand128(); tr = rand128();
    send_frame(8'h44, kr, tr, 0, -1);
    finish_frame();

    // Overrun in WAIT: error pulse, block unchanged.
    kr = rand128(); tr = rand128();
    send_frame(8'h45, kr, tr, 0, -1);
    idle(3);
    drive_byte(8'($urandom));
    err_q.push_back(last_cyc + 1);
    idle(2);
    @(negedge clk);
    chk("overrun_key", o_key, kr);
    chk("overrun_text", o_text, tr);
    finish_frame();

    // Overrun in the START cycle, then done together with a byte in WAIT.
    kr = rand128(); tr = rand128();
    send_frame(8'h44, kr, tr, 0, -1);
    drive_byte(8'h45);
    err_q.push_back(last_cyc + 1);
    idle(2);
    done = 1'b1;
    drive_byte(8'h44);
    done = 1'b0;
    err_q.push_back(last_cyc + 1);
    @(negedge clk);
    chk("done_with_byte_busy", 128'(o_busy), 128'd0);
    chk("done_with_byte_key", o_key, kr);
    @(posedge clk); #1;
    kr = rand128(); tr = rand128();
    send_frame(8'h45, kr, tr, -1, -1);
    finish_frame();

    // Reset after the 10th text byte discards the frame.
    drive_byte(8'h44);
    for (int i = 0; i < 26; i++) begin
      idle(1);
      drive_byte(8'($urandom));
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_zero("midreset");
    rst = 1'b0;
    @(posedge clk); #1;
    idle(4);
    kr = rand128(); tr = rand128();
    send_frame(8'h44, kr, tr, 2, -1);
    finish_frame();

    idle(10);
    chk("pending_starts", 128'(exp_q.size()), 128'd0);
    chk("pending_errs", 128'(err_q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_frame_rx.md
Name: aes_frame_rx

Overview:
- Upstream stage of the AES core in the UART path.
- Receives a byte stream from the UART receiver and parses one command frame: a header byte, then 16 key bytes, then 16 text bytes.
- Presents the assembled 128-bit key and text, plus the enc/dec flag, to the AES core and pulses its start input.
- Holds all outputs stable until the core reports done, then accepts the next frame.

Parameters:
- TIMEOUT_CYC, 1000000, maximum clock cycles allowed between consecutive bytes inside a frame before the frame is aborted (must be ≥2).
- CMD_ENC, 8'h45, header byte selecting encryption.
- CMD_DEC, 8'h44, header byte selecting decryption.

Ports:
- i_Clk  in  1  single clock; all logic is on its rising edge.
- i_Rst  in  1  reset; synchronous and active-high.
- i_RxData  in  8  received UART byte.
- i_RxValid  in  1  one-cycle strobe; i_RxData is valid in that cycle.
- i_Done  in  1  AES core done flag (core o_fDone).
- o_Start  out  1  one-cycle start pulse to the AES core.
- o_fDec  out  1  1 = decrypt, 0 = encrypt.
- o_Key  out  128  assembled key.
- o_Text  out  128  assembled text.
- o_Busy  out  1  high from o_Start until i_Done is seen.
- o_Err  out  1  one-cycle pulse on timeout abort or overrun drop.

Behaviour:
- Reset (i_Rst high at a rising edge): state IDLE; byte count 0; timeout counter 0; o_Start=0, o_fDec=0, o_Key=0, o_Text=0, o_Busy=0, o_Err=0.
  - Applies in any state, including mid-frame and during WAIT. A partial frame is discarded.
- States: IDLE, KEY, TEXT, START, WAIT.
- IDLE:
  - Byte == CMD_ENC: latch o_fDec=0, go to KEY.
  - Byte == CMD_DEC: latch o_fDec=1, go to KEY.
  - Any other byte is silently ignored (no o_Err).
- KEY: each accepted byte updates o_Key <= {o_Key[119:0], byte}, so the first key byte ends in [127:120]. After the 16th byte, go to TEXT and clear the count.
- TEXT: same shifting into o_Text. On the edge that accepts the 16th byte, go to START.
- START:
  - o_Start=1 and o_Busy=1 for exactly this one cycle; o_Start is registered.
  - Latency: o_Start is high in the cycle immediately after the cycle carrying the 32nd data byte.
  - Always proceeds to WAIT.
- WAIT:
  - o_Busy=1.
  - On i_Done=1, go to IDLE and drop o_Busy in the next cycle.
  - A byte arriving in WAIT or START is dropped and o_Err pulses one cycle. o_Key and o_Text are unchanged.
- Register stability: o_Key, o_Text and o_fDec change only on accepted frame bytes, so they are stable throughout START/WAIT.
- Byte counter: 4 bits; wraps 15→0 on the KEY→TEXT transition.
- Timeout counter:
  - Width is $clog2(TIMEOUT_CYC+1).
  - Counts only in KEY and TEXT; reset to 0 by every accepted byte.
  - When it reaches TIMEOUT_CYC-1 with no byte in that cycle: go to IDLE, clear the count, pulse o_Err. o_Key and o_Text keep their partial contents, which are don't-care.
- Simultaneous events:
  - Byte in the same cycle as timeout expiry: the byte wins and the counter restarts.
  - i_Done outside WAIT is ignored.
  - i_Done and i_RxValid together in WAIT: the byte is dropped with o_Err, and the transition to IDLE still occurs.

Decomposition:
- Package aes_uart_pkg holds:
  - state encoding (IDLE=3'd0, KEY=3'd1, TEXT=3'd2, START=3'd3, WAIT=3'd4);
  - CMD_ENC and CMD_DEC defaults;
  - FRAME_BYTES=16.
- One natural sub-module: rx_timeout_timer.
  - Inputs: enable, restart.
  - Output: expire pulse.
  - Parameterised by TIMEOUT_CYC.
  - The frame FSM and shift registers stay in aes_frame_rx.

Test Plan:
- Encrypt frame: send 8'h45, key bytes 00..0f, text bytes 00,11,22,...,ff, with 3 idle cycles between bytes.
  - Expect o_Key=128'h000102030405060708090a0b0c0d0e0f and o_Text=128'h00112233445566778899aabbccddeeff.
  - Expect o_fDec=0 and a single o_Start pulse one cycle after the last byte.
  - Expect o_Busy high until i_Done is asserted.
- Decrypt frame: header 8'h44, same key, text 128'h69c4e0d86a7b0430d8cdb78070b4c55a.
  - Expect o_fDec=1, the matching o_Text, and one o_Start pulse.
- Garbage and timeout:
  - Send 8'h00, 8'h41 in IDLE: expect no state change and no o_Err.
  - With TIMEOUT_CYC=20, send the header and 5 key bytes, then idle 20 cycles: expect an o_Err pulse and return to IDLE.
  - A following full frame completes correctly.
- Overrun: send a byte while in WAIT.
  - Expect one o_Err pulse and o_Key/o_Text unchanged.
  - Assert i_Done: o_Busy falls next cycle.
- Reset mid-frame: assert i_Rst after the 10th text byte.
  - Expect all outputs 0 on the next edge and no o_Start.
  - A fresh frame afterwards is accepted.
- Boundary timing: a byte arriving exactly in the timeout-expiry cycle is accepted (no o_Err), and the frame completes.
